// File: rtl/tlb_types.sv
// Shared TLB types: array write/read entry, invalidate command and the
// maintenance sequencer's op/state encodings.
package tlb_types;

  localparam logic [5:0] REFILL_ECODE = 6'h3F;

  typedef enum logic [2:0] {
    OpSrch = 3'd0,
    OpRd   = 3'd1,
    OpWr   = 3'd2,
    OpFill = 3'd3,
    OpInv  = 3'd4
  } tlb_ctrl_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StSwait,
    StExec,
    StResp
  } tlb_ctrl_state_t;

  typedef struct packed {
    logic        e;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
    logic        v0;
    logic        d0;
    logic [1:0]  mat0;
    logic [1:0]  plv0;
    logic [19:0] ppn0;
    logic        v1;
    logic        d1;
    logic [1:0]  mat1;
    logic [1:0]  plv1;
    logic [19:0] ppn1;
  } tlb_wr_port;

  typedef struct packed {
    logic        en;
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [18:0] vpn;
  } tlb_inv_in_struct;

endpackage

// File: rtl/tlb_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: drives the TLB array ports and
// returns one result beat per accepted instruction.
module tlb_ctrl
  import tlb_types::*;
#(
  parameter int unsigned TLBNUM = 32,
  parameter int unsigned IW     = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [4:0]       req_inv_op,
  input  logic [9:0]       req_inv_asid,
  input  logic [18:0]      req_inv_vpn,
  input  logic             flush,
  input  tlb_wr_port       csr_entry,
  input  logic [IW-1:0]    csr_tlbidx_index,
  input  logic             csr_tlbidx_ne,
  input  logic [5:0]       csr_ecode,
  output logic             s1_fetch,
  output logic [18:0]      s1_vppn,
  output logic             s1_odd_page,
  output logic [9:0]       s1_asid,
  input  logic             s1_found,
  input  logic [IW-1:0]    s1_index,
  output logic [IW-1:0]    r_index,
  input  tlb_wr_port       read_port,
  output logic             we,
  output logic [IW-1:0]    w_index,
  output tlb_wr_port       write_port,
  output tlb_inv_in_struct inv_o,
  output logic             resp_valid,
  output logic [2:0]       resp_op,
  output logic             resp_found,
  output logic [IW-1:0]    resp_index,
  output tlb_wr_port       resp_entry,
  output logic             resp_ill
);

  tlb_ctrl_state_t state_q, state_d;
  logic [IW-1:0]   fill_ctr_q;
  logic            accept;
  tlb_wr_port      wr_entry;

  assign req_ready   = (state_q == StIdle) && rst_n && !flush;
  assign accept      = req_valid && req_ready;
  assign s1_fetch    = accept && (req_op == OpSrch);
  assign s1_vppn     = s1_fetch ? csr_entry.vppn : '0;
  assign s1_asid     = s1_fetch ? csr_entry.asid : '0;
  assign s1_odd_page = 1'b0;
  assign r_index     = csr_tlbidx_index;

  // A refill exception always installs a valid entry; otherwise TLBIDX.NE decides.
  always_comb begin
    wr_entry   = csr_entry;
    wr_entry.e = (csr_ecode == REFILL_ECODE) ? 1'b1 : ~csr_tlbidx_ne;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (req_op == OpSrch) ? StSwait : StExec;
      StSwait: state_d = flush ? StIdle : StResp;
      StExec:  state_d = StIdle;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ctr_q <= '0;
    end else if (fill_ctr_q == IW'(TLBNUM - 1)) begin
      fill_ctr_q <= '0;
    end else begin
      fill_ctr_q <= fill_ctr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we         <= 1'b0;
      w_index    <= '0;
      write_port <= '0;
      inv_o      <= '0;
      resp_valid <= 1'b0;
      resp_op    <= '0;
      resp_found <= 1'b0;
      resp_index <= '0;
      resp_entry <= '0;
      resp_ill   <= 1'b0;
    end else begin
      we         <= 1'b0;
      inv_o.en   <= 1'b0;
      resp_valid <= 1'b0;
      if (accept) begin
        resp_op  <= req_op;
        resp_ill <= 1'b0;
        case (req_op)
          OpSrch: ;
          OpRd: begin
            resp_entry <= read_port.e ? read_port : '0;
            resp_valid <= 1'b1;
          end
          OpWr, OpFill: begin
            we         <= 1'b1;
            w_index    <= (req_op == OpFill) ? fill_ctr_q : csr_tlbidx_index;
            write_port <= wr_entry;
            resp_valid <= 1'b1;
          end
          OpInv: begin
            inv_o.en   <= (req_inv_op <= 5'd6);
            inv_o.op   <= req_inv_op;
            inv_o.asid <= req_inv_asid;
            inv_o.vpn  <= req_inv_vpn;
            resp_ill   <= (req_inv_op > 5'd6);
            resp_valid <= 1'b1;
          end
          default: begin
            resp_ill   <= 1'b1;
            resp_valid <= 1'b1;
          end
        endcase
      end
      // Array search result is valid in SWAIT; a flush there drops the response.
      if (state_q == StSwait && !flush) begin
        resp_found <= s1_found;
        resp_index <= s1_index;
        resp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
- Sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Sits between the commit-side CSR/instruction logic and the 32-entry TLB array.
- Drives the array's search port 1, read port, write port and invalidate port.
- Returns results (search hit/index, read entry) for CSR update through a single-beat valid/ready handshake.

Parameters:
- TLBNUM, 32, number of TLB entries; index width IW = $clog2(TLBNUM).
- REFILL_ECODE, 6'h3F, ESTAT.Ecode value that forces E=1 on TLBWR/TLBFILL.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  instruction request
- req_ready  out  1  high only in IDLE
- req_op  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV; 5-7 illegal
- req_inv_op  in  5  INVTLB op
- req_inv_asid  in  10  INVTLB asid
- req_inv_vpn  in  19  INVTLB vpn
- flush  in  1  pipeline flush
- csr_entry  in  tlb_wr_port  fields assembled from TLBEHI/TLBELO0/1/TLBIDX.PS/ASID
- csr_tlbidx_index  in  IW  TLBIDX.Index
- csr_tlbidx_ne  in  1  TLBIDX.NE
- csr_ecode  in  6  ESTAT.Ecode
- s1_fetch  out  1  search strobe to array
- s1_vppn  out  19  search vppn
- s1_odd_page  out  1  search odd-page bit
- s1_asid  out  10  search asid
- s1_found  in  1  array hit, valid the cycle after s1_fetch
- s1_index  in  IW  array hit index
- r_index  out  IW  array read index
- read_port  in  tlb_wr_port  array read data, combinational
- we  out  1  array write enable
- w_index  out  IW  array write index
- write_port  out  tlb_wr_port  array write data
- inv_o  out  tlb_inv_in_struct  invalidate command
- resp_valid  out  1  one-cycle result pulse
- resp_op  out  3  op of the completed request
- resp_found  out  1  SRCH hit
- resp_index  out  IW  SRCH hit index
- resp_entry  out  tlb_wr_port  RD data
- resp_ill  out  1  illegal op or INVTLB op > 6

Behaviour:
- Reset values: all outputs 0; state IDLE; fill_ctr 0.
- Exception: req_ready = (state==IDLE) && !rst, combinational.
- States:
  - IDLE: accept on req_valid && req_ready.
    - SRCH -> SWAIT.
    - Any other op -> EXEC.
  - SWAIT: one cycle; -> RESP.
  - EXEC: one cycle; -> IDLE.
  - RESP: one cycle; -> IDLE.
- SRCH:
  - In the accept cycle, s1_fetch=1 combinationally, with s1_vppn=csr_entry.vppn, s1_asid=csr_entry.asid, s1_odd_page=0.
  - In SWAIT, register s1_found/s1_index.
  - resp_valid=1 in RESP, i.e. accept edge + 2.
- RD:
  - r_index=csr_tlbidx_index at all times.
  - At the accept edge, capture read_port.
  - If read_port.e==0, resp_entry is captured as all-zero.
  - resp_valid in EXEC, accept edge + 1.
- WR/FILL:
  - At the accept edge, register w_index and write_port = csr_entry with e = (csr_ecode==REFILL_ECODE) ? 1 : ~csr_tlbidx_ne.
  - w_index = csr_tlbidx_index for WR; fill_ctr for FILL.
  - we=1 exactly one cycle (EXEC); resp_valid in the same cycle.
- fill_ctr: free-running, +1 every cycle, wraps TLBNUM-1 -> 0. FILL uses the value present in the accept cycle.
- INV:
  - For req_inv_op <= 6, inv_o.en=1 for one cycle (EXEC), with op/asid/vpn registered at accept.
  - For req_inv_op > 6, en stays 0 and resp_ill=1.
- Illegal req_op 5-7: EXEC with no array side effect, resp_ill=1.
- flush:
  - In SWAIT, go to IDLE with no resp_valid.
  - In EXEC or RESP, ignored; the write/inv already committed.
  - In IDLE, a same-cycle req is not accepted (req_ready=0 when flush=1).
- Only one request is outstanding. Back-to-back WR then SRCH is the minimum of 1 idle-gap cycle, and the search sees the new entry.
- Async reset mid-operation: state to IDLE; we/inv_o.en/resp_valid drop immediately.

Decomposition:
- tlb_types gets:
  - tlb_ctrl_op_t enum (SRCH/RD/WR/FILL/INV)
  - tlb_ctrl_state_t
  - REFILL_ECODE constant
- tlb_wr_port and tlb_inv_in_struct are reused from tlb_types.
- No sub-module. fill_ctr stays inline.

Test Plan:
- WR index 5 (vppn 0x12345, ps 12, e via ne=0), then SRCH vppn 0x12345 asid match -> we pulse 1 cycle with w_index=5; resp_found=1, resp_index=5, resp_valid at accept+2.
- RD index 5 after WR; RD index 6 (e=0) -> resp_entry matches written fields; second response is all-zero entry.
- FILL with csr_ecode=0x3F, ne=1 -> write_port.e=1, w_index equals fill_ctr sampled at accept; counter wraps 31->0 verified over 32 cycles.
- INV op 5 with asid 0x3 and vpn 0x12345 -> inv_o.en one-cycle pulse with fields; INV op 9 -> no en, resp_ill=1.
- SRCH accepted, flush in SWAIT -> no resp_valid, req_ready high the next cycle.
- rst_n low during EXEC of WR -> we and resp_valid drop asynchronously, state IDLE, fill_ctr=0.
